apb_mem_slave: RTL
==================

# apb_mem_slave

Parametrised APB4 memory slave, the next generation of the team's APB memory model. Adds byte-addressed word storage with write strobes, a programmable wait-state count, and a slave error on out-of-range or misaligned access. It sits behind the APB interconnect as a scratch/config RAM and as the default target for UVM APB agent regressions.

## Interface
- ADDR_WIDTH, 12: paddr width, byte address.
- DATA_WIDTH, 32: data bus width; must be 8, 16, 32 or 64.
- MEM_DEPTH, 256: number of DATA_WIDTH words stored.
- WAIT_STATES, 0: access-phase cycles with pready=0 before completion, 0..15.
- pclk  in  1  single clock; all logic on its rising edge.
- prst  in  1  reset, asynchronous, active-high.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_WIDTH  byte address.
- pw_data  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- pready  out  1  transfer complete.
- pr_data  out  DATA_WIDTH  read data.
- pslverr  out  1  transfer error; meaningful only with pready=1.

## Operation
- Word index = paddr >> log2(DATA_WIDTH/8); alignment bits = low log2(DATA_WIDTH/8) bits of paddr.
- Error condition: word index >= MEM_DEPTH, or alignment bits nonzero.
- FSM states: IDLE, ACCESS.
- IDLE: psel=1, penable=0 (setup) -> ACCESS, wait counter loaded with WAIT_STATES, error flag and address registered. Read: pr_data loaded from memory (0 on error). psel=1, penable=1 without a preceding setup is ignored: stay IDLE, pready=0.
- ACCESS: counter decrements each cycle while nonzero. pready = (state==ACCESS && counter==0), decoded from registers only.
- Completion edge (psel & penable & pready): write with no error updates only the bytes with pstrb[i]=1; write with error leaves memory unchanged; pslverr = registered error flag. FSM -> IDLE.
- Read with pstrb != 0 is accepted; pstrb is ignored.
- psel falling in ACCESS before pready: abort, FSM -> IDLE, no write, outputs return to reset values next cycle.
- Write to an address, then read of the same address on the next transfer, returns the new data.

## Timing
- Reset (prst=1, async): state IDLE, counter 0, pready=0, pslverr=0, pr_data=0, all memory words 0. Reset mid-transfer discards the transfer; no partial write.
- Setup cycle N; first access cycle N+1; pready=1 in cycle N+1+WAIT_STATES; transfer length 2+WAIT_STATES cycles.
- Back-to-back: the next setup may be presented in the cycle after the completion edge; no idle cycle is required.
- pr_data stable from the first access cycle through completion; held until the next read setup.
- pslverr=0 whenever pready=0.
- paddr, pwrite, pw_data and pstrb are sampled at setup and at completion only; changes during wait states are protocol violations, and their behaviour is unspecified.

## Structure
- Package apb_mem_pkg: state enum (IDLE, ACCESS); functions for strobe width and alignment shift; the WAIT_STATES maximum constant.
- Sub-module apb_mem_array: MEM_DEPTH x DATA_WIDTH storage with byte-enable synchronous write, synchronous read, and async-reset clear. The top module holds the FSM, wait counter and error decode.

## Test plan
- Reset: assert prst mid-write with WAIT_STATES=3 -> all outputs 0 immediately; a later read of that address returns 0x00000000.
- Full-word write then read: WAIT_STATES=0, write 0xDEADBEEF @0x010, then read @0x010 -> pready in the 2nd cycle of each transfer, pr_data=0xDEADBEEF, pslverr=0.
- Strobes: write 0xFFFFFFFF @0x020, then write 0x11223344 with pstrb=4'b0101, then read -> 0xFF22FF44.
- Errors: write @0x400 (MEM_DEPTH=256), read @0x402 (misaligned) -> pslverr=1 with pready on both; read @0x400 -> pr_data=0; memory unchanged.
- Wait states: WAIT_STATES=3, back-to-back read/write/read -> pready low for 3 access cycles each, each transfer 5 cycles, no idle cycle between transfers.
- Abort: drop psel in the 2nd wait cycle of a write @0x030 -> no pready, a later read of @0x030 returns its old value, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared types and helpers for the APB memory slave.
// FSM state encoding, strobe/alignment helpers and wait-state limit.
package apb_mem_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

  function automatic int align_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: word storage with byte-enable write and registered read.
// Read register can be cleared so the bus sees zeros after errors/aborts.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_we,
  input  logic [IDX_W-1:0]                 i_wr_idx,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [strb_width(DATA_WIDTH)-1:0] i_wr_be,
  input  logic                             i_rd_en,
  input  logic                             i_rd_clr,
  input  logic [IDX_W-1:0]                 i_rd_idx,
  output logic [DATA_WIDTH-1:0]            o_rd_data
);

  localparam int SW = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage: cleared on reset, byte lanes written where enabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wr_be[b]) begin
          r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read data register: clear wins over a load
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_clr) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 memory slave with wait states and slave error.
// FSM, wait counter and address/error decode; storage in apb_mem_array.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pw_data,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   pr_data,
  output logic                    pslverr
);

  localparam int SHIFT = align_shift(DATA_WIDTH);
  localparam int IDX_W =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WS_CLAMP =
    (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;

  localparam logic [CNT_W-1:0] LP_WAIT =
    CNT_W'(WS_CLAMP);
  localparam logic [ADDR_WIDTH-1:0] LP_ALIGN =
    ADDR_WIDTH'((1 << SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_DEPTH =
    ADDR_WIDTH'(MEM_DEPTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;

  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_we;
  logic                  w_rd_en;
  logic                  w_rd_clr;

  assign w_word = paddr >> SHIFT;
  assign w_err  = (w_word >= LP_DEPTH) ||
                  ((paddr & LP_ALIGN) != '0);

  assign pready  = (r_state == ACCESS) &&
                   (r_cnt == '0);
  assign pslverr = pready & r_err;

  assign w_setup = (r_state == IDLE) &&
                   psel && !penable;
  assign w_done  = (r_state == ACCESS) &&
                   psel && penable && pready;
  assign w_abort = (r_state == ACCESS) && !psel;

  assign w_we     = w_done && pwrite && !r_err;
  assign w_rd_en  = w_setup && !pwrite && !w_err;
  assign w_rd_clr = (w_setup && !pwrite && w_err) ||
                    w_abort;

  // Transfer FSM: capture at setup, count waits, finish or abort
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state <= ACCESS;
            r_cnt   <= LP_WAIT;
            r_err   <= w_err;
            r_idx   <= w_word[IDX_W-1:0];
          end
        end
        ACCESS: begin
          if (!psel) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end else if (w_done) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clk     (pclk),
    .i_rst     (prst),
    .i_we      (w_we),
    .i_wr_idx  (r_idx),
    .i_wr_data (pw_data),
    .i_wr_be   (pstrb),
    .i_rd_en   (w_rd_en),
    .i_rd_clr  (w_rd_clr),
    .i_rd_idx  (w_word[IDX_W-1:0]),
    .o_rd_data (pr_data)
  );

endmodule
